// File: rtl/mod_147_rcv_qualify.sv
// Receive-status qualifier: hysteresis on per-symbol decode results, producing
// loc_rcv_status for the link monitor (qualify on a good run, drop on error density or strobe loss).
module mod_147_rcv_qualify #(
   parameter int GOOD_COUNT  = 64,
   parameter int WINDOW      = 64,
   parameter int BAD_LIMIT   = 8,
   parameter int LOSS_CYCLES = 250
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       link_control,
   input  logic       sym_strobe,
   input  logic       sym_valid,
   output logic       loc_rcv_status,
   output logic [1:0] rcv_state,
   output logic [7:0] err_count
);

   typedef enum logic [1:0] {
      RCV_NOT_OK  = 2'b00,
      RCV_QUALIFY = 2'b01,
      RCV_OK      = 2'b10
   } rcv_state_t;

   localparam logic [7:0] GOOD_LIM = 8'(GOOD_COUNT);
   localparam logic [7:0] WIN_LIM  = 8'(WINDOW);
   localparam logic [7:0] BAD_LIM  = 8'(BAD_LIMIT);
   localparam logic [7:0] LOSS_LIM = 8'(LOSS_CYCLES);

   rcv_state_t state_r;
   logic       status_r;
   logic [7:0] good_cnt_r;
   logic [7:0] win_cnt_r;
   logic [7:0] err_cnt_r;
   logic [7:0] loss_cnt_r;

   logic [7:0] good_inc_s;
   logic [7:0] win_inc_s;
   logic [7:0] err_inc_s;
   logic       loss_expire_s;

   // Incremented counter values and loss-timer expiry for the current edge
   always_comb begin
      good_inc_s    = good_cnt_r + 8'd1;
      win_inc_s     = win_cnt_r + 8'd1;
      err_inc_s     = sym_valid ? err_cnt_r : (err_cnt_r + 8'd1);
      // A strobe on the expiry edge counts as activity, so it suppresses the drop.
      loss_expire_s = !sym_strobe && (loss_cnt_r != LOSS_LIM) &&
                      ((loss_cnt_r + 8'd1) == LOSS_LIM);
   end

   // Qualification state machine with its counters and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= RCV_NOT_OK;
         status_r   <= 1'b0;
         good_cnt_r <= 8'd0;
         win_cnt_r  <= 8'd0;
         err_cnt_r  <= 8'd0;
         loss_cnt_r <= 8'd0;
      end else if (link_control) begin
         state_r    <= RCV_NOT_OK;
         status_r   <= 1'b0;
         good_cnt_r <= 8'd0;
         win_cnt_r  <= 8'd0;
         err_cnt_r  <= 8'd0;
         loss_cnt_r <= 8'd0;
      end else begin
         if (sym_strobe) begin
            loss_cnt_r <= 8'd0;
         end else if (loss_cnt_r != LOSS_LIM) begin
            loss_cnt_r <= loss_cnt_r + 8'd1;
         end else begin
            loss_cnt_r <= loss_cnt_r;
         end

         if (loss_expire_s && (state_r != RCV_NOT_OK)) begin
            state_r    <= RCV_NOT_OK;
            status_r   <= 1'b0;
            good_cnt_r <= 8'd0;
            win_cnt_r  <= 8'd0;
            err_cnt_r  <= 8'd0;
         end else if (sym_strobe) begin
            case (state_r)
               RCV_NOT_OK: begin
                  if (sym_valid) begin
                     state_r    <= RCV_QUALIFY;
                     good_cnt_r <= 8'd1;
                  end
               end
               RCV_QUALIFY: begin
                  if (!sym_valid) begin
                     state_r    <= RCV_NOT_OK;
                     good_cnt_r <= 8'd0;
                  end else if (good_inc_s == GOOD_LIM) begin
                     state_r    <= RCV_OK;
                     status_r   <= 1'b1;
                     good_cnt_r <= 8'd0;
                     win_cnt_r  <= 8'd0;
                     err_cnt_r  <= 8'd0;
                  end else begin
                     good_cnt_r <= good_inc_s;
                  end
               end
               RCV_OK: begin
                  // Error-limit drop wins over the window clear on the same strobe.
                  if (!sym_valid && (err_inc_s == BAD_LIM)) begin
                     state_r    <= RCV_NOT_OK;
                     status_r   <= 1'b0;
                     good_cnt_r <= 8'd0;
                     win_cnt_r  <= 8'd0;
                     err_cnt_r  <= 8'd0;
                  end else if (win_inc_s == WIN_LIM) begin
                     win_cnt_r <= 8'd0;
                     err_cnt_r <= 8'd0;
                  end else begin
                     win_cnt_r <= win_inc_s;
                     err_cnt_r <= err_inc_s;
                  end
               end
               default: begin
                  state_r    <= RCV_NOT_OK;
                  status_r   <= 1'b0;
                  good_cnt_r <= 8'd0;
                  win_cnt_r  <= 8'd0;
                  err_cnt_r  <= 8'd0;
               end
            endcase
         end
      end
   end

   assign loc_rcv_status = status_r;
   assign rcv_state      = state_r;
   assign err_count      = err_cnt_r;

endmodule

// File: doc/mod_147_rcv_qualify.md
# mod_147_rcv_qualify

Receive-status qualifier for the Clause 147 PHY. Sits directly upstream of the link monitor state diagram and generates the `loc_rcv_status` input it consumes. It watches the per-symbol decode result from the PCS receive path and applies hysteresis: it qualifies the receiver only after a run of consecutive good symbols. It disqualifies the receiver on an excessive error density within a sliding symbol window, or on loss of symbol strobes.

## Interface
Parameters:
- `GOOD_COUNT`, 64: consecutive valid symbols required to qualify. Legal range 2..255.
- `WINDOW`, 64: length, in symbols, of the error-density window while qualified. Legal range 1..255.
- `BAD_LIMIT`, 8: invalid symbols within one window that force disqualification. Legal range 1..WINDOW.
- `LOSS_CYCLES`, 250: clocks without `sym_strobe` that force disqualification. Legal range 1..255.

Ports:
- `clk`  in  1: block clock. The only clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `link_control`  in  1: 0 = ENABLE, 1 = DISABLE.
- `sym_strobe`  in  1: one-clock pulse, one per received symbol period.
- `sym_valid`  in  1: qualifies `sym_strobe`. 1 = symbol decoded valid, 0 = code violation. Ignored when `sym_strobe` = 0.
- `loc_rcv_status`  out  1: 1 = OK, 0 = NOT_OK. Feeds the link monitor.
- `rcv_state`  out  2: current state. 00 RCV_NOT_OK, 01 RCV_QUALIFY, 10 RCV_OK.
- `err_count`  out  8: invalid symbols counted in the current window. Zero outside RCV_OK.

## Operation
- All state, counters and outputs are registered on the rising edge of `clk`. `reset_n` low clears them asynchronously.
- Reset values:
  - `rcv_state` = 00 and `loc_rcv_status` = 0.
  - `err_count`, `good_cnt`, `win_cnt` and `loss_cnt` = 0.
- `loc_rcv_status` = 1 exactly when `rcv_state` = RCV_OK.
- **Priority 1:** `link_control` = 1 on any edge → RCV_NOT_OK, and all counters are cleared. Strobes are ignored while disabled.
- **Priority 2:** loss timer.
  - `loss_cnt` clears on every `sym_strobe`. Otherwise it increments and saturates at LOSS_CYCLES.
  - In RCV_QUALIFY or RCV_OK, the edge on which `loss_cnt` would reach LOSS_CYCLES → RCV_NOT_OK, and counters are cleared.
  - The timer keeps running in RCV_NOT_OK but has no effect there.
- **RCV_NOT_OK:**
  - Strobe with `sym_valid` = 1 → RCV_QUALIFY, with `good_cnt` = 1.
  - Strobe with `sym_valid` = 0 → stay.
- **RCV_QUALIFY:**
  - Valid strobe → `good_cnt`++. If the new value equals GOOD_COUNT → RCV_OK, with `good_cnt`, `win_cnt` and `err_count` cleared.
  - Invalid strobe → RCV_NOT_OK, with `good_cnt` = 0.
- **RCV_OK:**
  - Each strobe increments `win_cnt`. An invalid strobe also increments `err_count`.
  - If the incremented `err_count` equals BAD_LIMIT → RCV_NOT_OK, and counters are cleared.
  - Otherwise, if the incremented `win_cnt` equals WINDOW → `win_cnt` and `err_count` both clear and the state stays RCV_OK.
- Simultaneous events:
  - Disqualification on BAD_LIMIT takes precedence over the window clear on the same strobe.
  - A strobe coinciding with the loss-timer expiry counts as activity: `loss_cnt` clears and there is no loss drop.
- Counter width is 8 bits. Parameters outside their legal ranges are unsupported and need no checking.

## Timing
- A strobe sampled on edge N takes effect on edge N. New outputs are visible after edge N; there is no further pipeline.
- Qualify latency: `loc_rcv_status` rises on the edge that samples the GOOD_COUNT-th consecutive valid strobe.
- Error drop: `loc_rcv_status` falls on the edge that samples the BAD_LIMIT-th invalid strobe of a window.
- Loss drop: `loc_rcv_status` falls LOSS_CYCLES edges after the last strobe, with the strobe edge counted as 0.
- Disable drop: `loc_rcv_status` falls on the first edge sampling `link_control` = 1.
- Reset assertion clears all outputs immediately, with no clock required. Operation resumes from RCV_NOT_OK on the first edge after deassertion.

## Test plan
1. **Reset:** assert `reset_n` = 0 mid-RCV_OK without clocking → `loc_rcv_status` = 0, `rcv_state` = 00 and `err_count` = 0 immediately.
2. **Qualify:**
   - Drive 64 valid strobes, one every 4 clocks → `rcv_state` = 01 after strobe 1, and `loc_rcv_status` = 1 after strobe 64.
   - Repeat with 63 valid strobes then 1 invalid → back to 00, and `loc_rcv_status` stays 0.
3. **Error density:**
   - In RCV_OK, send 7 invalid strobes among 64 → remains OK, and `err_count` returns to 0 after strobe 64.
   - Then send 8 invalid strobes within the next window → drop on the 8th.
   - Boundary case: make the 8th error the 64th strobe of the window → drop.
4. **Loss:**
   - In RCV_OK, stop strobes → `loc_rcv_status` = 0 exactly 250 clocks after the last strobe.
   - A strobe at clock 250 keeps the state at RCV_OK.
5. **Disable:**
   - Set `link_control` = 1 in RCV_OK → drop on the next edge.
   - Keep sending 100 valid strobes while disabled → stays 00.
   - Release `link_control` → requires 64 new valid strobes to qualify.
6. **Reset mid-qualify:** assert `reset_n` low after 30 valid strobes, then release → `good_cnt` restarts, so 64 further valid strobes are needed to reach RCV_OK.
